quantum_timer_ctrl: RTL

//  Multi-channel preemption timer for the processor's scheduler. Each channel counts

---
 rtl/quantum_timer_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/quantum_timer_ctrl.sv
// Multi-channel preemption timer: per-channel quantum counters with sticky pending flags,
// merged into one lowest-index-first interrupt with ack. Define QTC_OVERRUN_EN for overrun flags.
module qtc_channel #(
  parameter int WIDTH           = 32,
  parameter int DEFAULT_QUANTUM = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_quantum,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  output logic             pending,
  output logic             running,
  output logic             overrun
);
  logic [WIDTH-1:0] cnt, q;
  logic             expire;

  // >= rather than == so a quantum shrunk below the live count still expires next edge
  assign expire = running && (q != '0) && (cnt >= q - WIDTH'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      q       <= WIDTH'(DEFAULT_QUANTUM);
      running <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (cfg_we) q <= cfg_quantum;
      if (stop) begin
        running <= 1'b0;
        pending <= 1'b0;
        if (start) cnt <= '0;
      end else if (start) begin
        running <= 1'b1;
        cnt     <= '0;
        if (ack) pending <= 1'b0;
      end else begin
        if (running) cnt <= (q == '0 || expire) ? '0 : cnt + WIDTH'(1);
        if (expire)   pending <= 1'b1;
        else if (ack) pending <= 1'b0;
      end
    end
  end

`ifdef QTC_OVERRUN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               overrun <= 1'b0;
    else if (stop || ack)                     overrun <= 1'b0;
    else if (expire && !start && pending)     overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif
endmodule

module quantum_timer_ctrl #(
  parameter  int NUM_CH          = 4,
  parameter  int WIDTH           = 32,
  parameter  int DEFAULT_QUANTUM = 20,
  localparam int CHW             = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0]  cfg_quantum,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic              irq_ack,
  output logic              irq,
  output logic [CHW-1:0]    irq_ch,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] overrun
);
  logic [NUM_CH-1:0] ack_vec, we_vec;

  assign irq = |pending;

  always_comb begin
    irq_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pending[i]) irq_ch = CHW'(i);
  end

  assign ack_vec = (irq_ack && irq) ? (NUM_CH'(1) << irq_ch) : '0;
  assign we_vec  = cfg_we ? (NUM_CH'(1) << cfg_ch) : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    qtc_channel #(.WIDTH(WIDTH), .DEFAULT_QUANTUM(DEFAULT_QUANTUM)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .cfg_we      (we_vec[g]),
      .cfg_quantum (cfg_quantum),
      .start       (start[g]),
      .stop        (stop[g]),
      .ack         (ack_vec[g]),
      .pending     (pending[g]),
      .running     (running[g]),
      .overrun     (overrun[g])
    );
  end
endmodule
